// File: rtl/eth_phy_10g_rx_gearbox.sv
// eth_phy_10g_rx_gearbox
//   Receive-side 32/64-to-66 gearbox for a 10GBASE-R PHY. It packs LSB-first
//   SERDES words into 66-bit blocks (2-bit sync header plus 64-bit payload).
//   It also implements the frame-sync bit-slip by discarding exactly one
//   received bit for each request.
//
// Ports
//   clk                   rising-edge clock for all logic
//   rst                   synchronous active-high reset
//   serdes_rx_data        raw received bits, bit 0 received first
//   serdes_rx_data_valid  serdes_rx_data carries new bits this cycle
//   serdes_rx_bitslip     single-cycle pulse: drop one received bit
//   encoded_rx_data       block payload, bit 0 = first payload bit received
//   encoded_rx_hdr        sync header, bit 0 = first bit of the block
//   encoded_rx_valid      one-cycle strobe: data/hdr hold a new block
//
// Handshake: encoded_rx_valid is a pure strobe with no ready. Downstream must
// take the block in the cycle valid is high. data/hdr hold their value otherwise.

module eth_phy_10g_rx_gearbox #(
    parameter int SERDES_WIDTH = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int HDR_WIDTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SERDES_WIDTH-1:0] serdes_rx_data,
    input  logic                    serdes_rx_data_valid,
    input  logic                    serdes_rx_bitslip,
    output logic [DATA_WIDTH-1:0]   encoded_rx_data,
    output logic [HDR_WIDTH-1:0]    encoded_rx_hdr,
    output logic                    encoded_rx_valid
);

    localparam int BLOCK_W = DATA_WIDTH + HDR_WIDTH;
    // Worst case: 65 leftover bits plus one full word.
    localparam int BUF_W   = BLOCK_W + SERDES_WIDTH - 1;
    localparam int CNT_W   = $clog2(BUF_W + 1);

    localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_W);
    localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(SERDES_WIDTH);

    // Illegal widths abort elaboration.
    if (SERDES_WIDTH != 32 && SERDES_WIDTH != 64) begin : g_bad_serdes_width
        $error("eth_phy_10g_rx_gearbox: SERDES_WIDTH must be 32 or 64");
    end
    if (DATA_WIDTH != 64) begin : g_bad_data_width
        $error("eth_phy_10g_rx_gearbox: DATA_WIDTH must be 64");
    end
    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
        $error("eth_phy_10g_rx_gearbox: HDR_WIDTH must be 2");
    end

    logic [BUF_W-1:0]      buf_q, buf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  slip_pending_q, slip_pending_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
    logic                  valid_q, valid_d;

    // Intermediate buffer/count after each of the three ordered steps.
    logic [BUF_W-1:0]      buf_app, buf_emit;
    logic [CNT_W-1:0]      cnt_app, cnt_emit;
    logic                  emit;

    always_comb begin
        buf_app        = buf_q;
        cnt_app        = cnt_q;
        buf_emit       = '0;
        cnt_emit       = '0;
        emit           = 1'b0;
        buf_d          = '0;
        cnt_d          = '0;
        slip_pending_d = slip_pending_q;
        data_d         = data_q;
        hdr_d          = hdr_q;
        valid_d        = 1'b0;

        // Step 1: append. cnt_q never exceeds BLOCK_W-1, so the word always fits.
        if (serdes_rx_data_valid) begin
            buf_app[cnt_q +: SERDES_WIDTH] = serdes_rx_data;
            cnt_app                        = cnt_q + WORD_CNT;
        end

        // Step 2: emit. At most one block fits, because cnt_app < 2*BLOCK_W.
        emit     = (cnt_app >= BLOCK_CNT);
        buf_emit = buf_app;
        cnt_emit = cnt_app;
        if (emit) begin
            hdr_d    = buf_app[HDR_WIDTH-1:0];
            data_d   = buf_app[BLOCK_W-1:HDR_WIDTH];
            valid_d  = 1'b1;
            buf_emit = buf_app >> BLOCK_W;
            cnt_emit = cnt_app - BLOCK_CNT;
        end

        // Step 3: slip. It drops the oldest bit left after any emit. An empty
        // buffer defers the slip. A second request while one is pending merges into it.
        buf_d = buf_emit;
        cnt_d = cnt_emit;
        if (serdes_rx_bitslip || slip_pending_q) begin
            if (cnt_emit != '0) begin
                buf_d          = buf_emit >> 1;
                cnt_d          = cnt_emit - 1'b1;
                slip_pending_d = 1'b0;
            end else begin
                slip_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q          <= '0;
            cnt_q          <= '0;
            slip_pending_q <= 1'b0;
            data_q         <= '0;
            hdr_q          <= '0;
            valid_q        <= 1'b0;
        end else begin
            buf_q          <= buf_d;
            cnt_q          <= cnt_d;
            slip_pending_q <= slip_pending_d;
            data_q         <= data_d;
            hdr_q          <= hdr_d;
            valid_q        <= valid_d;
        end
    end

    assign encoded_rx_data  = data_q;
    assign encoded_rx_hdr   = hdr_q;
    assign encoded_rx_valid = valid_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_gearbox.sv
// Self-checking bench for eth_phy_10g_rx_gearbox (SERDES_WIDTH = 32).
// Each test builds a serial bit stream from blocks and pushes the expected
// blocks into exp_q. The driver packs the stream into words. A monitor pops
// exp_q on every strobe and compares.
module tb_eth_phy_10g_rx_gearbox;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] serdes_rx_data = '0;
  logic          serdes_rx_data_valid = 1'b0;
  logic          serdes_rx_bitslip = 1'b0;
  logic [63:0]   encoded_rx_data;
  logic [1:0]    encoded_rx_hdr;
  logic          encoded_rx_valid;

  eth_phy_10g_rx_gearbox #(.SERDES_WIDTH(SW), .DATA_WIDTH(64), .HDR_WIDTH(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .serdes_rx_data       (serdes_rx_data),
    .serdes_rx_data_valid (serdes_rx_data_valid),
    .serdes_rx_bitslip    (serdes_rx_bitslip),
    .encoded_rx_data      (encoded_rx_data),
    .encoded_rx_hdr       (encoded_rx_hdr),
    .encoded_rx_valid     (encoded_rx_valid)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [65:0] exp_q[$];     // {hdr, data}
  logic        stream_q[$];  // serial bits, front = first received
  int          checks = 0;
  int          errors = 0;
  int          strobe_cnt = 0;
  int          discard_cnt = 0;
  bit          mon_check = 1'b1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #2;
    if (encoded_rx_valid === 1'b1) begin
      strobe_cnt++;
      if (!mon_check) begin
        discard_cnt++;
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block: got hdr=%b data=%h, want no strobe",
                 encoded_rx_hdr, encoded_rx_data);
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({encoded_rx_hdr, encoded_rx_data} !== e) begin
          errors++;
          $display("FAIL block: got hdr=%b data=%h, want hdr=%b data=%h",
                   encoded_rx_hdr, encoded_rx_data, e[65:64], e[63:0]);
        end
      end
    end
  end

  // ---------------- stream builders ----------------
  task automatic push_bit(input logic b);
    stream_q.push_back(b);
  endtask

  task automatic push_block(input logic [1:0] h, input logic [63:0] d, input bit expect_it);
    push_bit(h[0]);
    push_bit(h[1]);
    for (int k = 0; k < 64; k++) push_bit(d[k]);
    if (expect_it) exp_q.push_back({h, d});
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit junk, input bit check_out);
    @(negedge clk);
    rst = 1'b1;
    serdes_rx_data_valid = junk;
    serdes_rx_data = junk ? 32'hFFFF_FFFF : '0;
    serdes_rx_bitslip = junk;
    @(posedge clk);
    #1;
    if (check_out) begin
      chk("reset_valid", encoded_rx_valid, 0);
      chk("reset_data", encoded_rx_data, 0);
      chk("reset_hdr", encoded_rx_hdr, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    serdes_rx_data_valid = 1'b0;
    serdes_rx_data = '0;
    serdes_rx_bitslip = 1'b0;
    strobe_cnt = 0;
    discard_cnt = 0;
    mon_check = 1'b1;
  endtask

  // Sends the whole stream, zero-padded to whole words. Bitslip goes high with
  // word i when i = first_slip + n*period, for n < nslip.
  task automatic send_words(input int first_slip, input int period, input int nslip,
                            input int check_at, input int max_gap, input bit lat_chk);
    int nwords;
    nwords = (stream_q.size() + SW - 1) / SW;
    for (int i = 0; i < nwords; i++) begin
      logic [SW-1:0] w;
      w = '0;
      for (int b = 0; b < SW; b++) if (stream_q.size() > 0) w[b] = stream_q.pop_front();
      @(negedge clk);
      if (i == check_at) mon_check = 1'b1;
      serdes_rx_data = w;
      serdes_rx_data_valid = 1'b1;
      serdes_rx_bitslip = (nslip > 0) && (i >= first_slip) &&
                          (((i - first_slip) % period) == 0) &&
                          (((i - first_slip) / period) < nslip);
      if (lat_chk && (i == 1 || i == 2)) begin
        @(posedge clk);
        #1;
        chk(i == 1 ? "latency_word2" : "latency_word3", encoded_rx_valid, (i == 2));
      end
      if (max_gap > 0 && $urandom_range(0, 1) == 1) begin
        int g;
        g = $urandom_range(1, max_gap);
        repeat (g) begin
          @(negedge clk);
          serdes_rx_data_valid = 1'b0;
          serdes_rx_bitslip = 1'b0;
        end
      end
    end
    @(negedge clk);
    serdes_rx_data_valid = 1'b0;
    serdes_rx_bitslip = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_test(input string name, input int exp_strobes);
    chk({name, "_strobes"}, strobe_cnt, exp_strobes);
    chk({name, "_leftover"}, exp_q.size(), 0);
  endtask

  task automatic build_aligned();
    push_block(2'b01, 64'h0123456789ABCDEF, 1'b1);
    for (int i = 1; i <= 15; i++) push_block(2'b10, 64'(i), 1'b1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset state.
    do_reset(1'b0, 1'b1);

    // 1: aligned stream, 33 words -> 16 blocks; first strobe after word 3.
    build_aligned();
    send_words(0, 1, 0, -1, 0, 1'b1);
    end_test("aligned", 16);

    // 2: 5 junk bits ahead of the blocks, slips on words 0,8,16,24,32. The
    // 15 blocks emitted before the fifth slip are discarded. Blocks 15..19 follow aligned.
    do_reset(1'b0, 1'b0);
    push_bit(1'b1); push_bit(1'b0); push_bit(1'b1); push_bit(1'b1); push_bit(1'b0);
    for (int j = 0; j < 20; j++)
      push_block(j[0] ? 2'b10 : 2'b01, {32'hA5A5_5A5A, 32'(j * 3 + 7)}, (j >= 15));
    mon_check = 1'b0;
    send_words(0, 8, 5, 33, 0, 1'b0);
    chk("offset_discarded", discard_cnt, 15);
    end_test("offset", 20);

    // 3: slip while empty (twice, merged into one), then the stream; the
    // first bit is dropped.
    do_reset(1'b0, 1'b0);
    serdes_rx_bitslip = 1'b1;
    @(negedge clk);
    push_bit(1'b1);
    push_block(2'b01, 64'hFEDC_BA98_7654_3210, 1'b1);
    push_block(2'b10, 64'h0000_0000_0000_0001, 1'b1);
    send_words(0, 1, 0, -1, 0, 1'b0);
    end_test("empty_slip", 2);

    // 4: slip together with word 3. Block 0 is intact and stream bit 66 is dropped.
    do_reset(1'b0, 1'b0);
    push_block(2'b10, 64'hDEAD_BEEF_0000_0001, 1'b1);
    push_bit(1'b1);
    push_block(2'b01, 64'h5555_5555_5555_5555, 1'b1);
    push_block(2'b10, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
    send_words(2, 1, 1, -1, 0, 1'b0);
    end_test("emit_slip", 3);

    // 5: aligned stream with random 1-3 cycle valid gaps.
    do_reset(1'b0, 1'b0);
    build_aligned();
    send_words(0, 1, 0, -1, 3, 1'b0);
    end_test("gaps", 16);

    // 6: two junk words (cnt=64), then reset with junk inputs, then one fresh
    // block (hdr 11 passes through) that needs all three new words.
    repeat (64) push_bit(1'b1);
    send_words(0, 1, 0, -1, 0, 1'b0);
    do_reset(1'b1, 1'b1);
    push_block(2'b11, 64'h0F1E_2D3C_4B5A_6978, 1'b1);
    send_words(0, 1, 0, -1, 0, 1'b1);
    end_test("reset_mid", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
